// File: rtl/rv_pkg.sv
// Shared RV32I control definitions: opcodes, controller states, ALU op codes
// and datapath mux encodings.
package rv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  typedef enum logic [3:0] {
    FETCH, DECODE, EXEC_R, EXEC_I, MEMADR, MEMRD, MEMWB, MEMWR,
    BRANCH, JAL, JALR, LUI, AUIPC, ALUWB, TRAP
  } ctrl_state_t;

  // Which flavour of ALU control the current state wants.
  typedef enum logic [2:0] {
    ALU_CLS_NONE, ALU_CLS_ADD, ALU_CLS_R, ALU_CLS_I, ALU_CLS_BR
  } alu_cls_t;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SLL  = 3'b001;
  localparam logic [2:0] ALU_SLT  = 3'b010;
  localparam logic [2:0] ALU_SLTU = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_SRL  = 3'b101;
  localparam logic [2:0] ALU_OR   = 3'b110;
  localparam logic [2:0] ALU_AND  = 3'b111;

  localparam logic [1:0] SRCA_RS1   = 2'd0;
  localparam logic [1:0] SRCA_PC    = 2'd1;
  localparam logic [1:0] SRCA_OLDPC = 2'd2;
  localparam logic [1:0] SRCA_ZERO  = 2'd3;

  localparam logic [1:0] SRCB_RS2  = 2'd0;
  localparam logic [1:0] SRCB_IMM  = 2'd1;
  localparam logic [1:0] SRCB_FOUR = 2'd2;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  localparam logic [1:0] RES_ALUOUT = 2'd0;
  localparam logic [1:0] RES_MEM    = 2'd1;
  localparam logic [1:0] RES_ALU    = 2'd2;

  // funct3 010/011 are not defined for conditional branches.
  function automatic logic branch_f3_ok(input logic [2:0] f3);
    return f3[2:1] != 2'b01;
  endfunction

endpackage

// File: rtl/alu_dec.sv
// Combinational ALU control decode: {state class, funct3, instr[30]} to the
// ALU's aluCntrl/useF7/inv/loadStore inputs.
module alu_dec
  import rv_pkg::*;
(
  input  alu_cls_t   cls,
  input  logic [2:0] funct3,
  input  logic       bit30,
  output logic [2:0] aluCntrl,
  output logic       useF7,
  output logic       inv,
  output logic       loadStore
);

  always_comb begin
    aluCntrl  = ALU_ADD;
    useF7     = 1'b0;
    inv       = 1'b0;
    loadStore = 1'b0;
    case (cls)
      ALU_CLS_ADD: loadStore = 1'b1;
      ALU_CLS_R: begin
        aluCntrl = funct3;
        useF7    = bit30 && (funct3 == ALU_ADD || funct3 == ALU_SRL);
      end
      ALU_CLS_I: begin
        // Only SRAI uses bit 30; for ADDI it is just an immediate bit.
        aluCntrl = funct3;
        useF7    = bit30 && (funct3 == ALU_SRL);
      end
      ALU_CLS_BR: begin
        case (funct3)
          3'b000: useF7 = 1'b1;
          3'b001: begin useF7 = 1'b1; inv = 1'b1; end
          3'b100: aluCntrl = ALU_SLT;
          3'b101: begin aluCntrl = ALU_SLT; inv = 1'b1; end
          3'b110: aluCntrl = ALU_SLTU;
          3'b111: begin aluCntrl = ALU_SLTU; inv = 1'b1; end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback,
// owns the instruction register and drives the ALU control and datapath strobes.
module multicycle_ctrl
  import rv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] memRdata,
  input  logic        memReady,
  input  logic        branchFlag,
  output logic        memReq,
  output logic        memWrite,
  output logic [2:0]  aluCntrl,
  output logic        useF7,
  output logic        inv,
  output logic        loadStore,
  output logic [1:0]  srcASel,
  output logic [1:0]  srcBSel,
  output logic [2:0]  immSel,
  output logic [1:0]  resultSel,
  output logic        pcWrite,
  output logic        regWrite,
  output logic [31:0] instr,
  output logic [31:0] pcNext,
  output logic        illegal
);

  ctrl_state_t state_reg, state_next;
  logic [31:0] instr_reg;
  alu_cls_t    alu_cls;
  logic [2:0]  funct3;
  logic        is_store;

  assign instr    = instr_reg;
  assign funct3   = instr_reg[14:12];
  assign is_store = instr_reg[5];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= FETCH;
      instr_reg <= INSTR_NOP;
    end else begin
      state_reg <= state_next;
      if (state_reg == FETCH && memReady)
        instr_reg <= memRdata;
    end
  end

  always_comb begin
    state_next = state_reg;
    alu_cls    = ALU_CLS_NONE;
    memReq     = 1'b0;
    memWrite   = 1'b0;
    srcASel    = SRCA_RS1;
    srcBSel    = SRCB_RS2;
    immSel     = IMM_I;
    resultSel  = RES_ALUOUT;
    pcWrite    = 1'b0;
    regWrite   = 1'b0;
    pcNext     = 32'h0;
    illegal    = 1'b0;
    case (state_reg)
      FETCH: begin
        memReq    = 1'b1;
        srcASel   = SRCA_PC;
        srcBSel   = SRCB_FOUR;
        alu_cls   = ALU_CLS_ADD;
        resultSel = RES_ALU;
        if (memReady) begin
          pcWrite    = 1'b1;
          state_next = DECODE;
        end
      end
      DECODE: begin
        // Precompute the branch target into the ALU result register.
        srcASel = SRCA_OLDPC;
        srcBSel = SRCB_IMM;
        immSel  = IMM_B;
        alu_cls = ALU_CLS_ADD;
        case (instr_reg[6:0])
          OP_R:              state_next = EXEC_R;
          OP_I:              state_next = EXEC_I;
          OP_LOAD, OP_STORE: state_next = MEMADR;
          OP_BRANCH:         state_next = BRANCH;
          OP_JAL:            state_next = JAL;
          OP_JALR:           state_next = JALR;
          OP_LUI:            state_next = LUI;
          OP_AUIPC:          state_next = AUIPC;
          default:           state_next = TRAP;
        endcase
      end
      EXEC_R: begin
        alu_cls    = ALU_CLS_R;
        state_next = ALUWB;
      end
      EXEC_I: begin
        alu_cls    = ALU_CLS_I;
        srcBSel    = SRCB_IMM;
        state_next = ALUWB;
      end
      MEMADR: begin
        alu_cls    = ALU_CLS_ADD;
        srcBSel    = SRCB_IMM;
        immSel     = is_store ? IMM_S : IMM_I;
        state_next = is_store ? MEMWR : MEMRD;
      end
      MEMRD: begin
        memReq = 1'b1;
        if (memReady) state_next = MEMWB;
      end
      MEMWB: begin
        resultSel  = RES_MEM;
        regWrite   = 1'b1;
        state_next = FETCH;
      end
      MEMWR: begin
        memReq   = 1'b1;
        memWrite = 1'b1;
        if (memReady) state_next = FETCH;
      end
      BRANCH: begin
        if (branch_f3_ok(funct3)) begin
          alu_cls    = ALU_CLS_BR;
          pcWrite    = branchFlag;
          state_next = FETCH;
        end else begin
          state_next = TRAP;
        end
      end
      JAL: begin
        alu_cls    = ALU_CLS_ADD;
        srcASel    = SRCA_OLDPC;
        srcBSel    = SRCB_IMM;
        immSel     = IMM_J;
        pcWrite    = 1'b1;
        regWrite   = 1'b1;
        state_next = FETCH;
      end
      JALR: begin
        alu_cls    = ALU_CLS_ADD;
        srcBSel    = SRCB_IMM;
        pcWrite    = 1'b1;
        regWrite   = 1'b1;
        state_next = FETCH;
      end
      LUI: begin
        alu_cls    = ALU_CLS_ADD;
        srcASel    = SRCA_ZERO;
        srcBSel    = SRCB_IMM;
        immSel     = IMM_U;
        state_next = ALUWB;
      end
      AUIPC: begin
        alu_cls    = ALU_CLS_ADD;
        srcASel    = SRCA_OLDPC;
        srcBSel    = SRCB_IMM;
        immSel     = IMM_U;
        state_next = ALUWB;
      end
      ALUWB: begin
        regWrite   = 1'b1;
        resultSel  = RES_ALUOUT;
        state_next = FETCH;
      end
      TRAP: illegal = 1'b1;
      default: state_next = FETCH;
    endcase
    // Reset overrides everything, including a pending memory handshake.
    if (rst) begin
      state_next = FETCH;
      alu_cls    = ALU_CLS_NONE;
      memReq     = 1'b0;
      memWrite   = 1'b0;
      srcASel    = SRCA_RS1;
      srcBSel    = SRCB_RS2;
      immSel     = IMM_I;
      resultSel  = RES_ALUOUT;
      pcWrite    = 1'b0;
      regWrite   = 1'b0;
      illegal    = 1'b0;
      pcNext     = RESET_PC;
    end
  end

  alu_dec u_alu_dec (
    .cls       (alu_cls),
    .funct3    (funct3),
    .bit30     (instr_reg[30]),
    .aluCntrl  (aluCntrl),
    .useF7     (useF7),
    .inv       (inv),
    .loadStore (loadStore)
  );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed testbench for multicycle_ctrl: table of instructions with expected
// execute-cycle strobes and cycle counts, plus handshake/trap/reset sequences.
module tb_multicycle_ctrl;

  localparam logic [31:0] RST_PC = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] memRdata;
  logic        memReady;
  logic        branchFlag;
  logic        memReq, memWrite, useF7, inv, loadStore, pcWrite, regWrite, illegal;
  logic [2:0]  aluCntrl, immSel;
  logic [1:0]  srcASel, srcBSel, resultSel;
  logic [31:0] instr, pcNext;

  int checks = 0;
  int errors = 0;

  multicycle_ctrl #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst), .memRdata(memRdata), .memReady(memReady),
    .branchFlag(branchFlag), .memReq(memReq), .memWrite(memWrite),
    .aluCntrl(aluCntrl), .useF7(useF7), .inv(inv), .loadStore(loadStore),
    .srcASel(srcASel), .srcBSel(srcBSel), .immSel(immSel),
    .resultSel(resultSel), .pcWrite(pcWrite), .regWrite(regWrite),
    .instr(instr), .pcNext(pcNext), .illegal(illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string       name;
    logic [31:0] word;
    logic        bf;
    logic [2:0]  alu;
    logic        f7;
    logic        iv;
    logic        ls;
    logic [1:0]  sa;
    logic [1:0]  sb;
    logic [2:0]  imm;
    logic        pcw;
    logic        rw;
    int          cycles;
  } vec_t;

  logic [18:0] strobes;
  logic [16:0] exec_obs;
  logic        fetch_sig;
  assign strobes   = {memReq, memWrite, aluCntrl, useF7, inv, loadStore, srcASel,
                      srcBSel, immSel, resultSel, pcWrite, regWrite};
  assign exec_obs  = {aluCntrl, useF7, inv, loadStore, srcASel, srcBSel, immSel,
                      pcWrite, regWrite, memReq, memWrite};
  assign fetch_sig = memReq && !memWrite && srcASel == 2'd1 && srcBSel == 2'd2;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[17];

  initial begin
    int n;
    vecs[0]  = '{"sub",    32'h40B5_0533, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 3'd0, 1'b0, 1'b0, 4};
    vecs[1]  = '{"addi",   32'hC000_0093, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 3'd0, 1'b0, 1'b0, 4};
    vecs[2]  = '{"srai",   32'h4010_D093, 1'b0, 3'd5, 1'b1, 1'b0, 1'b0, 2'd0, 2'd1, 3'd0, 1'b0, 1'b0, 4};
    vecs[3]  = '{"andi",   32'h4001_7093, 1'b0, 3'd7, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 3'd0, 1'b0, 1'b0, 4};
    vecs[4]  = '{"xor",    32'h4020_C0B3, 1'b0, 3'd4, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 3'd0, 1'b0, 1'b0, 4};
    vecs[5]  = '{"sra",    32'h4020_D0B3, 1'b0, 3'd5, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 3'd0, 1'b0, 1'b0, 4};
    vecs[6]  = '{"bne_t",  32'h0020_9463, 1'b1, 3'd0, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 3'd0, 1'b1, 1'b0, 3};
    vecs[7]  = '{"bne_nt", 32'h0020_9463, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 3'd0, 1'b0, 1'b0, 3};
    vecs[8]  = '{"beq_t",  32'h0020_8463, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 3'd0, 1'b1, 1'b0, 3};
    vecs[9]  = '{"blt_t",  32'h0020_C463, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 3'd0, 1'b1, 1'b0, 3};
    vecs[10] = '{"bgeu_nt",32'h0020_F463, 1'b0, 3'd3, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 3'd0, 1'b0, 1'b0, 3};
    vecs[11] = '{"lw",     32'h0001_2083, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd1, 3'd0, 1'b0, 1'b0, 5};
    vecs[12] = '{"sw",     32'h0011_2023, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd1, 3'd1, 1'b0, 1'b0, 4};
    vecs[13] = '{"lui",    32'h1234_5037, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 2'd3, 2'd1, 3'd3, 1'b0, 1'b0, 4};
    vecs[14] = '{"auipc",  32'h0000_0097, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 2'd2, 2'd1, 3'd3, 1'b0, 1'b0, 4};
    vecs[15] = '{"jal",    32'h0080_00EF, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 2'd2, 2'd1, 3'd4, 1'b1, 1'b1, 3};
    vecs[16] = '{"jalr",   32'h0000_80E7, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd1, 3'd0, 1'b1, 1'b1, 3};

    // Reset
    rst = 1'b1; memRdata = 32'h0; memReady = 1'b0; branchFlag = 1'b0;
    tick(); tick();
    check("reset_strobes", {45'd0, strobes}, 64'd0);
    check("reset_illegal", {63'd0, illegal}, 64'd0);
    check("reset_pcnext", {32'd0, pcNext}, {32'd0, RST_PC});
    rst = 1'b0; #1;
    check("first_fetch_req", {62'd0, fetch_sig, pcWrite}, 64'h2);
    check("reset_instr_nop", {32'd0, instr}, 64'h13);
    check("pcnext_zero", {32'd0, pcNext}, 64'd0);
    tick();
    check("fetch_wait_hold", {63'd0, fetch_sig}, 64'd1);

    // Table-driven instructions with memReady permanently high
    for (int i = 0; i < 17; i++) begin
      memRdata = vecs[i].word; memReady = 1'b1; branchFlag = vecs[i].bf; #1;
      check({vecs[i].name, "_fetch"}, {62'd0, fetch_sig, pcWrite}, 64'h3);
      tick();
      check({vecs[i].name, "_instr"}, {32'd0, instr}, {32'd0, vecs[i].word});
      check({vecs[i].name, "_decode"}, {55'd0, srcASel, srcBSel, immSel, loadStore, memReq},
            {55'd0, 2'd2, 2'd1, 3'd2, 1'b1, 1'b0});
      tick();
      check({vecs[i].name, "_exec"}, {47'd0, exec_obs},
            {47'd0, vecs[i].alu, vecs[i].f7, vecs[i].iv, vecs[i].ls, vecs[i].sa,
             vecs[i].sb, vecs[i].imm, vecs[i].pcw, vecs[i].rw, 1'b0, 1'b0});
      n = 3;
      tick();
      while (!fetch_sig && n < 12) begin
        n++;
        tick();
      end
      check({vecs[i].name, "_cycles"}, 64'(n), 64'(vecs[i].cycles));
    end

    // Load with three wait states in MEMRD
    memRdata = 32'h0001_2083; memReady = 1'b1; branchFlag = 1'b0; #1;
    tick();
    memReady = 1'b0;
    tick(); tick();
    for (int k = 0; k < 4; k++) begin
      if (k == 3) memReady = 1'b1;
      #1;
      check("lw_wait_memreq", {62'd0, memReq, memWrite}, 64'h2);
      if (k < 3) tick();
    end
    tick();
    check("lw_memwb", {60'd0, resultSel, regWrite, memReq}, {60'd0, 2'd1, 1'b1, 1'b0});
    tick();
    check("lw_back_fetch", {63'd0, fetch_sig}, 64'd1);

    // Illegal opcode traps and stays trapped until reset
    memRdata = 32'hFFFF_FFFF; memReady = 1'b1; #1;
    tick(); tick();
    check("trap_entry", {63'd0, illegal}, 64'd1);
    branchFlag = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("trap_sticky", {44'd0, illegal, strobes}, {44'd0, 1'b1, 19'd0});
    end
    rst = 1'b1; #1;
    check("trap_rst_cycle", {63'd0, illegal}, 64'd0);
    tick();
    rst = 1'b0; branchFlag = 1'b0; #1;
    check("trap_rst_fetch", {62'd0, fetch_sig, illegal}, 64'h2);

    // Reset during a stalled store
    memRdata = 32'h0011_2023; memReady = 1'b1; #1;
    tick();
    memReady = 1'b0;
    tick(); tick();
    check("sw_memwr", {62'd0, memReq, memWrite}, 64'h3);
    tick();
    check("sw_memwr_held", {62'd0, memReq, memWrite}, 64'h3);
    rst = 1'b1; #1;
    check("sw_rst_cycle", {62'd0, memReq, memWrite}, 64'h0);
    tick();
    check("sw_rst_next", {62'd0, memReq, memWrite}, 64'h0);
    rst = 1'b0; #1;
    check("sw_rst_fetch", {62'd0, fetch_sig, memWrite}, 64'h2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle control FSM for the RV32I core, and the driving end of the ALU control interface. It sequences each instruction through fetch, decode, execute, memory and writeback. Every cycle it drives the ALU's `aluCntrl`/`useF7`/`inv`/`loadStore` inputs, and it consumes the ALU's `branchFlag`. It also owns the instruction register and the datapath mux/enable strobes, and handshakes with a single shared instruction/data memory port.

## Interface
- `RESET_PC`, default 32'h0000_0000: value placed on `pcNext` during the reset cycle.
- `clk` in 1: rising-edge clock.
- `rst` in 1: synchronous, active-high reset.
- `memRdata` in 32: memory read data; holds the instruction word in FETCH.
- `memReady` in 1: memory accepts or completes the current `memReq` this cycle.
- `branchFlag` in 1: ALU branch-condition result.
- `memReq` out 1: memory access request, held until `memReady`.
- `memWrite` out 1: the current request is a store.
- `aluCntrl` out 3: ALU operation, funct3 encoding.
- `useF7` out 1: selects SUB (op 000) and SRA (op 101).
- `inv` out 1: inverts the branch condition.
- `loadStore` out 1: forces the ALU to add.
- `srcASel` out 2: ALU A mux. 0 = rs1, 1 = PC, 2 = old PC, 3 = zero.
- `srcBSel` out 2: ALU B mux. 0 = rs2, 1 = imm, 2 = const 4.
- `immSel` out 3: immediate format. I, S, B, U, J.
- `resultSel` out 2: writeback mux. 0 = ALU result register, 1 = memory data, 2 = live ALU output.
- `pcWrite` out 1: PC register write enable.
- `regWrite` out 1: register-file write enable.
- `instr` out 32: the instruction register.
- `pcNext` out 32: not driven by this block's datapath. Tied to `RESET_PC` in the reset cycle, otherwise 0.
- `illegal` out 1: sticky trap flag.

## Operation
- States: FETCH, DECODE, EXEC_R, EXEC_I, MEMADR, MEMRD, MEMWB, MEMWR, BRANCH, JAL, JALR, LUI, AUIPC, ALUWB, TRAP.
- FETCH:
  - `memReq=1`, `srcASel=1`, `srcBSel=2`, `loadStore=1`, `resultSel=2`.
  - On `memReady`: `instr`←`memRdata`, `pcWrite=1`, then go to DECODE. Otherwise stay in FETCH.
- DECODE: dispatch on `instr[6:0]`:
  - 0110011 → EXEC_R
  - 0010011 → EXEC_I
  - 0000011 and 0100011 → MEMADR
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 1100111 → JALR
  - 0110111 → LUI
  - 0010111 → AUIPC
  - anything else → TRAP
- EXEC_R:
  - `aluCntrl=funct3`, `srcASel=0`, `srcBSel=0`.
  - `useF7=instr[30]` only when funct3 is 000 or 101; otherwise 0.
  - Next: ALUWB.
- EXEC_I:
  - `aluCntrl=funct3`, `srcBSel=1`, I-format immediate.
  - `useF7=instr[30]` only when funct3=101. ADDI never subtracts.
- MEMADR:
  - `loadStore=1`, `srcBSel=1`, immediate I (load) or S (store).
  - Next: MEMRD for a load, MEMWR for a store.
- MEMRD: `memReq=1` until `memReady`, then MEMWB.
- MEMWB: `resultSel=1`, `regWrite=1`, then FETCH.
- MEMWR: `memReq=1`, `memWrite=1` until `memReady`, then FETCH.
- BRANCH: funct3 maps to the ALU as follows:
  - 000 → op 000, `useF7=1`, `inv=0`
  - 001 → op 000, `useF7=1`, `inv=1`
  - 100 → op 010, `inv=0`
  - 101 → op 010, `inv=1`
  - 110 → op 011, `inv=0`
  - 111 → op 011, `inv=1`
  - 010 and 011 → TRAP
  - `pcWrite=branchFlag`. The target is taken from the ALU result register, which holds oldPC+immB computed during DECODE (`srcASel=2`, `srcBSel=1`, `loadStore=1`).
- JAL and JALR:
  - One cycle each, `regWrite=1` with the link value.
  - JAL: `pcWrite=1` with the target old PC + immJ.
  - JALR: `pcWrite=1` with the target rs1+immI; bit 0 is cleared by the datapath.
- LUI uses `srcASel=3`. AUIPC uses `srcASel=2`. Both then go to ALUWB.
- ALUWB: `regWrite=1`, `resultSel=0`, then FETCH.
- TRAP: `illegal=1`, sticky. All strobes stay at 0 until reset.
- Default for every strobe in every state not listed: 0.

## Timing
- While `rst` is high, the next state is FETCH and `instr`←32'h0000_0013 (NOP).
  - All outputs are 0 in the reset cycle, `memReq` included.
  - `pcNext=RESET_PC` in the reset cycle.
- The first `memReq` is asserted in the cycle after `rst` deasserts.
- Outputs are a combinational decode of the state register and `instr`. They are stable all cycle, and no output depends on `memRdata` except the `instr` load.
- Memory handshake:
  - `memReq`, `memWrite` and the address sources are held constant until the cycle in which `memReady=1`.
  - The transition happens on that edge.
  - `memReady` without `memReq` is ignored.
  - `memReady` held permanently high gives zero-wait behaviour.
- Cycle counts with zero wait states:
  - R/I-type, LUI, AUIPC: 4
  - load: 5
  - store: 4
  - branch: 3
  - JAL/JALR: 3
- Reset asserted in any state, including mid-handshake, wins over all other transitions on that edge.

## Structure
- Shared package `rv_pkg`:
  - opcode localparams
  - `ctrl_state_t` enum
  - ALU op constants (`ALU_ADD`=3'b000 … `ALU_AND`=3'b111)
  - mux-select constants for `srcASel`, `srcBSel`, `immSel`, `resultSel`
- Sub-module `alu_dec`: purely combinational. Maps {state class, funct3, instr[30]} to `aluCntrl`/`useF7`/`inv`/`loadStore`.
- The FSM and the instruction register live in `multicycle_ctrl`.

## Test plan
- Reset, then `memRdata`=32'h40B5_0533 (sub) with `memReady` high → states FETCH, DECODE, EXEC_R (`aluCntrl`=000, `useF7`=1), ALUWB (`regWrite`=1), then FETCH.
- addi x1,x0,-1024 (32'hC000_0093) → EXEC_I with `aluCntrl`=000 and `useF7`=0; srai 32'h4010_D093 → `aluCntrl`=101 with `useF7`=1.
- bne (32'h0020_9463) with `branchFlag`=1 → BRANCH with `aluCntrl`=000, `useF7`=1, `inv`=1, `pcWrite`=1; repeat with `branchFlag`=0 → `pcWrite`=0.
- lw with `memReady` low for 3 cycles in MEMRD → `memReq` held for 4 cycles; MEMWB follows with `resultSel`=1 and `regWrite`=1.
- Opcode 7'b1111111 → TRAP and `illegal`=1; `illegal` stays 1 for 10 cycles with all strobes at 0; assert `rst` → FETCH and `illegal`=0.
- Assert `rst` during MEMWR while waiting on `memReady` → next cycle is FETCH with `memReq`=0 and `memWrite`=0.
